// File: rtl/mem_resp.sv
// Word-organised memory with wait states and little-endian byte access.
// Misaligned accesses take a second cycle to reach the next word.
module mem_resp #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT        = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [1:0]  i_do,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_val,
   output logic [31:0] o_val,
   output logic        o_ready,
   output logic        o_done,
   output logic        o_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACC_LO,
      S_ACC_HI,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          wr_q, wr_d;
   logic          bad_q, bad_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [31:0]   wdat_q, wdat_d;
   logic [31:0]   lo_q, lo_d;
   logic [31:0]   val_q, val_d;
   logic          err_q, err_d;

   logic [31:0]   mem [DEPTH_WORDS];

   logic          req_ok;
   logic          accept;
   logic [32:0]   last_b;
   logic [1:0]    off;
   logic [AW-1:0] w_lo, w_hi;
   logic [7:0]    be;
   logic [63:0]   wd64;
   logic [31:0]   rd32;
   logic          lo_we, hi_we;

   assign req_ok  = (i_do == 2'b01) || (i_do == 2'b10);
   assign o_ready = (state_q == S_IDLE) || (state_q == S_DONE);
   assign o_done  = (state_q == S_DONE);
   assign accept  = o_ready && req_ok;
   assign o_val   = val_q;
   assign o_err   = err_q;

   // 33-bit sum so a wrap past 0xFFFFFFFF still reads as out of range
   assign last_b = {1'b0, i_addr} + 33'd3;

   assign off  = addr_q[1:0];
   assign w_lo = addr_q[AW+1:2];
   assign w_hi = w_lo + AW'(1);
   assign be   = 8'h0F << off;
   assign wd64 = {32'h0, wdat_q} << {off, 3'b000};
   assign rd32 = 32'({mem[w_hi], lo_q} >> {off, 3'b000});

   assign lo_we = (state_q == S_ACC_LO) && wr_q && !bad_q;
   assign hi_we = (state_q == S_ACC_HI) && wr_q && !bad_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      bad_d   = bad_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      lo_d    = lo_q;
      val_d   = val_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               state_d = (WAIT == 0) ? S_ACC_LO : S_WAIT;
               cnt_d   = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
               wr_d    = (i_do == 2'b10);
               bad_d   = (last_b >= LIMIT);
               addr_d  = i_addr[AW+1:0];
               wdat_d  = i_val;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_ACC_LO;
            else cnt_d = cnt_q - 4'd1;
         end
         S_ACC_LO: begin
            lo_d = mem[w_lo];
            if (off == 2'd0) begin
               state_d = S_DONE;
               err_d   = bad_q;
               val_d   = (wr_q || bad_q) ? 32'h0 : mem[w_lo];
            end else begin
               state_d = S_ACC_HI;
            end
         end
         S_ACC_HI: begin
            state_d = S_DONE;
            err_d   = bad_q;
            val_d   = (wr_q || bad_q) ? 32'h0 : rd32;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         bad_q   <= 1'b0;
         addr_q  <= '0;
         wdat_q  <= 32'h0;
         lo_q    <= 32'h0;
         val_q   <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         bad_q   <= bad_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         lo_q    <= lo_d;
         val_q   <= val_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge i_clk) begin
      for (int b = 0; b < 4; b++) begin
         if (lo_we && be[b])
            mem[w_lo][8*b +: 8] <= wd64[8*b +: 8];
         if (hi_we && be[b+4])
            mem[w_hi][8*b +: 8] <= wd64[32+8*b +: 8];
      end
   end

endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp: WAIT=2 and WAIT=0 instances.
module tb_mem_resp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic        rst_a, rst_b;
   logic [1:0]  do_a, do_b;
   logic [31:0] addr_a, addr_b, val_a, val_b;
   logic [31:0] oval_a, oval_b;
   logic        rdy_a, rdy_b, done_a, done_b, err_a, err_b;

   mem_resp #(.DEPTH_WORDS(1024), .WAIT(2)) dut_a (
      .i_clk(clk), .i_rst(rst_a), .i_do(do_a), .i_addr(addr_a),
      .i_val(val_a), .o_val(oval_a), .o_ready(rdy_a),
      .o_done(done_a), .o_err(err_a)
   );

   mem_resp #(.DEPTH_WORDS(1024), .WAIT(0)) dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_do(do_b), .i_addr(addr_b),
      .i_val(val_b), .o_val(oval_b), .o_ready(rdy_b),
      .o_done(done_b), .o_err(err_b)
   );

   typedef struct {
      logic [31:0] val;
      logic        err;
      int          lat;
      int          t0;
      string       name;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   localparam logic [1:0] RD = 2'b01;
   localparam logic [1:0] WR = 2'b10;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_a && done_a) begin
         if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_extra_done: got o_done=1 want 0");
         end else begin
            ea = qa.pop_front();
            chk({ea.name, "_val"}, oval_a, ea.val);
            chk({ea.name, "_err"}, 32'(err_a), 32'(ea.err));
            chk({ea.name, "_lat"}, 32'(cyc - ea.t0), 32'(ea.lat));
         end
      end
      if (!rst_b && done_b) begin
         if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_extra_done: got o_done=1 want 0");
         end else begin
            eb = qb.pop_front();
            chk({eb.name, "_val"}, oval_b, eb.val);
            chk({eb.name, "_err"}, 32'(err_b), 32'(eb.err));
            chk({eb.name, "_lat"}, 32'(cyc - eb.t0), 32'(eb.lat));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge
   task automatic req(input int which, input logic [1:0] op,
                      input logic [31:0] addr, input logic [31:0] wv,
                      input logic [31:0] ev, input logic ee,
                      input int lat, input string nm,
                      output logic b2b);
      exp_t e;
      int n = 0;
      b2b = 1'b0;
      while (!(which == 0 ? rdy_a : rdy_b) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL %s_ready_timeout: got o_ready=0 want 1", nm);
         return;
      end
      b2b = (which == 0) ? done_a : done_b;
      e.val = ev; e.err = ee; e.lat = lat; e.t0 = cyc; e.name = nm;
      if (which == 0) begin
         do_a = op; addr_a = addr; val_a = wv; qa.push_back(e);
      end else begin
         do_b = op; addr_b = addr; val_b = wv; qb.push_back(e);
      end
      @(negedge clk);
      if (which == 0) do_a = 2'b00;
      else do_b = 2'b00;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL %s_drain_timeout: got %0d pending want 0",
                  nm, qa.size() + qb.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic b2b;
      int   seen;
      rst_a = 1'b1; rst_b = 1'b1;
      do_a = 2'b00; addr_a = 32'h0; val_a = 32'h0;
      do_b = 2'b00; addr_b = 32'h0; val_b = 32'h0;
      repeat (3) @(negedge clk);
      chk("a_rst_ready", 32'(rdy_a), 32'd1);
      chk("a_rst_done", 32'(done_a), 32'd0);
      chk("a_rst_val", oval_a, 32'h0);
      chk("a_rst_err", 32'(err_a), 32'd0);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);

      req(0, WR, 32'h10, 32'h11223344, 32'h0, 1'b0, 4, "a_wr10", b2b);
      req(0, RD, 32'h10, 32'h0, 32'h11223344, 1'b0, 4, "a_rd10", b2b);
      req(0, WR, 32'h14, 32'hAABBCCDD, 32'h0, 1'b0, 4, "a_wr14", b2b);
      req(0, RD, 32'h12, 32'h0, 32'hCCDD1122, 1'b0, 5, "a_rd12", b2b);
      req(0, WR, 32'h13, 32'hDEADBEEF, 32'h0, 1'b0, 5, "a_wr13", b2b);
      req(0, RD, 32'h10, 32'h0, 32'hEF223344, 1'b0, 4, "a_rd10b", b2b);
      chk("a_b2b_rd10b", 32'(b2b), 32'd1);
      req(0, RD, 32'h14, 32'h0, 32'hAADEADBE, 1'b0, 4, "a_rd14", b2b);
      chk("a_b2b_rd14", 32'(b2b), 32'd1);
      req(0, RD, 32'hFFE, 32'h0, 32'h0, 1'b1, 5, "a_rdFFE", b2b);
      req(0, RD, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b1, 5, "a_rdwrap", b2b);
      req(0, WR, 32'hFFC, 32'h0BADF00D, 32'h0, 1'b0, 4, "a_wrFFC", b2b);
      req(0, WR, 32'hFFE, 32'h12345678, 32'h0, 1'b1, 5, "a_wrFFE", b2b);
      req(0, RD, 32'h1000, 32'h0, 32'h0, 1'b1, 4, "a_rd1000", b2b);
      req(0, RD, 32'hFFC, 32'h0, 32'h0BADF00D, 1'b0, 4, "a_rdFFC", b2b);
      drain("a");
      repeat (3) @(negedge clk);
      chk("a_hold_val", oval_a, 32'h0BADF00D);
      chk("a_hold_done", 32'(done_a), 32'd0);

      req(1, WR, 32'h0, 32'h55667788, 32'h0, 1'b0, 2, "b_wr0", b2b);
      req(1, RD, 32'h0, 32'h0, 32'h55667788, 1'b0, 2, "b_rd0", b2b);
      req(1, WR, 32'h8, 32'h44332211, 32'h0, 1'b0, 2, "b_wr8", b2b);
      req(1, WR, 32'hC, 32'h88776655, 32'h0, 1'b0, 2, "b_wrC", b2b);
      req(1, RD, 32'hA, 32'h0, 32'h66554433, 1'b0, 3, "b_rdA", b2b);
      drain("b");

      do_b = WR; addr_b = 32'h21; val_b = 32'hCAFEBABE;
      @(negedge clk);
      do_b = 2'b00;
      chk("b_inflight_ready", 32'(rdy_b), 32'd0);
      @(posedge clk);
      #2;
      rst_b = 1'b1;
      #1;
      chk("b_rst_ready", 32'(rdy_b), 32'd1);
      chk("b_rst_done", 32'(done_b), 32'd0);
      chk("b_rst_val", oval_b, 32'h0);
      chk("b_rst_err", 32'(err_b), 32'd0);
      @(negedge clk);
      rst_b = 1'b0;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (done_b) seen++;
      end
      chk("b_no_done_after_rst", 32'(seen), 32'd0);
      req(1, RD, 32'h0, 32'h0, 32'h55667788, 1'b0, 2, "b_rd0_post", b2b);
      drain("b_post");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two, at least 4).
REQ-002 SHALL have parameter WAIT, default 2, meaning the number of wait-state cycles inserted before each access (0..15).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_do, input, 2 bits: request type, 2'b00 NONE, 2'b01 READ, 2'b10 WRITE; 2'b11 treated as NONE.
REQ-006 SHALL have port i_addr, input, 32 bits: byte address, little-endian.
REQ-007 SHALL have port i_val, input, 32 bits: write data.
REQ-008 SHALL have port o_val, output, 32 bits: read data, valid while o_done=1.
REQ-009 SHALL have port o_ready, output, 1 bit: high when a new request can be accepted.
REQ-010 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port o_err, output, 1 bit: qualifies o_done; the request addressed out-of-range bytes.

Function
REQ-012 SHALL accept a request at a rising edge where o_ready=1 and i_do is READ or WRITE, registering i_do, i_addr and i_val; inputs are ignored at all other times.
REQ-013 SHALL implement states IDLE, WAIT, ACC_LO, ACC_HI and DONE.
REQ-014 Transitions SHALL be: IDLE->WAIT on accept (IDLE->ACC_LO if WAIT=0); WAIT->ACC_LO after WAIT cycles, counted by a 4-bit down-counter; ACC_LO->DONE if aligned, ->ACC_HI if misaligned; ACC_HI->DONE; DONE->IDLE, or DONE->WAIT/ACC_LO on a same-edge accept.
REQ-015 o_ready SHALL be 1 in IDLE and DONE only, allowing back-to-back requests without a bubble.
REQ-016 o_done SHALL be 1 only in DONE, exactly once per accepted request.
REQ-017 Latency from the accept edge to o_done high SHALL be WAIT+2 edges when i_addr[1:0]=0, and WAIT+3 edges otherwise.
REQ-018 Word index SHALL be i_addr[31:2]; a misaligned access SHALL touch word index w (ACC_LO) and w+1 (ACC_HI).
REQ-019 READ SHALL return bytes addr..addr+3, with the byte at addr in o_val[7:0].
REQ-020 WRITE SHALL store i_val[7:0] at addr through i_val[31:24] at addr+3, changing no other byte; misaligned writes SHALL update only the affected lanes of each of the two words.
REQ-021 Out-of-range SHALL mean any of bytes addr..addr+3 falls at or above 4*DEPTH_WORDS; addr+3 computed in 33 bits, so 32-bit wrap counts as out-of-range.
REQ-022 An out-of-range request SHALL take the same latency, write nothing, and complete with o_err=1 and o_val=0.
REQ-023 o_val and o_err SHALL hold their last values outside DONE; o_val after a WRITE SHALL be 0.
REQ-024 Storage SHALL have no reset; contents are undefined until written.

Reset
REQ-025 Asserting i_rst SHALL immediately force state IDLE, counter 0, o_ready=1, o_done=0, o_err=0 and o_val=0.
REQ-026 A request in flight when i_rst asserts SHALL be abandoned: an unfinished misaligned write may leave ACC_LO lanes updated, and no o_done follows.
REQ-027 The first accept SHALL occur at the first rising edge after i_rst deasserts at which i_do is valid.

Verification
REQ-028 WAIT=2: WRITE 0x11223344 to 0x10, then READ 0x10 -> each o_done 4 edges after accept; read o_val=0x11223344, o_err=0.
REQ-029 Memory preloaded with 0x11223344 at 0x10 and 0xAABBCCDD at 0x14: READ 0x12 -> o_val=0xCCDD1122 after 5 edges; then WRITE 0xDEADBEEF to 0x13 -> words become 0xEF223344 and 0xAADEADBE.
REQ-030 DEPTH_WORDS=1024: READ 0xFFE and READ 0xFFFFFFFE -> o_err=1, o_val=0, memory unchanged.
REQ-031 Back-to-back: issue a new READ on the DONE-cycle edge -> accepted with no idle cycle; exactly one o_done per request.
REQ-032 WAIT=0: aligned READ -> o_done 2 edges after accept; assert i_rst during ACC_HI of a misaligned write -> o_ready=1 and o_done=0 immediately, and no o_done follows.
